// File: rtl/ex_flush_ctrl_pkg.sv
// Shared constants and types for the exception/ERET flush controller.
package ex_flush_ctrl_pkg;

    localparam logic [31:0] EX_VEC_DEF = 32'hbfc00380;
    localparam logic [4:0]  EX_INT     = 5'h00;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned EXT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    // An interrupt is deliverable when any unmasked line is pending and none is in service.
    function automatic logic int_pending(input logic [7:0] ip, input logic [7:0] im,
                                         input logic ie, input logic exl);
        return (|(ip & im)) & ie & ~exl;
    endfunction

endpackage

// File: rtl/ex_flush_ctrl_int_sync.sv
// Multi-flop synchroniser for asynchronous level signals.
module int_sync #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] chain [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) chain[i] <= '0;
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < int'(DEPTH); i++) chain[i] <= chain[i-1];
        end
    end

    assign sync_out = chain[DEPTH-1];

endmodule

// File: rtl/ex_flush_ctrl.sv
// Pipeline recovery after exception/ERET commit (flush then PC redirect),
// plus interrupt request generation towards ID.
module ex_flush_ctrl
    import ex_flush_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_VEC    = EX_VEC_DEF,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_status_ie,
    input  logic        cp0_status_exl,
    input  logic [7:0]  cp0_status_im,
    input  logic [7:0]  cp0_cause_ip,
    input  logic [5:0]  ext_int_in,
    input  logic        int_ack,
    input  logic        fs_redirect_ack,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        int_req,
    output logic [5:0]  ext_int_sync,
    output logic        busy
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             trig_c;
    logic             has_int_c;

    assign trig_c    = ws_valid & (ws_ex | ws_eret);
    assign has_int_c = int_pending(cp0_cause_ip, cp0_status_im, cp0_status_ie, cp0_status_exl);

    int_sync #(
        .WIDTH (EXT_W),
        .DEPTH (SYNC_STG)
    ) u_int_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (ext_int_in),
        .sync_out (ext_int_sync)
    );

    // Recovery sequencer; int_req is only offered while idle and drops on ack or trigger.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= EX_VEC;
            int_req        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            int_req <= (state == ST_IDLE) & has_int_c & ~trig_c & ~(int_ack & int_req);
            case (state)
                ST_IDLE: begin
                    if (trig_c) begin
                        state       <= ST_FLUSH;
                        busy        <= 1'b1;
                        flush       <= 1'b1;
                        cnt         <= FLUSH_LOAD;
                        redirect_pc <= ws_ex ? EX_VEC : cp0_epc;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        state          <= ST_REDIR;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_REDIR: begin
                    if (fs_redirect_ack) begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// Randomised scoreboard bench for ex_flush_ctrl.
module tb_ex_flush_ctrl;

    localparam logic [31:0] VEC = 32'hbfc00380;
    localparam int          FC  = 1;
    localparam int          SS  = 2;

    logic        clk, resetn;
    logic        ws_valid, ws_ex, ws_eret;
    logic [31:0] cp0_epc;
    logic        cp0_status_ie, cp0_status_exl;
    logic [7:0]  cp0_status_im, cp0_cause_ip;
    logic [5:0]  ext_int_in;
    logic        int_ack, fs_redirect_ack;
    logic        flush, redirect_valid, int_req, busy;
    logic [31:0] redirect_pc;
    logic [5:0]  ext_int_sync;

    int total = 0;
    int bad   = 0;

    ex_flush_ctrl #(
        .EX_VEC    (VEC),
        .FLUSH_CYC (FC),
        .SYNC_STG  (SS)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_valid        (ws_valid),
        .ws_ex           (ws_ex),
        .ws_eret         (ws_eret),
        .cp0_epc         (cp0_epc),
        .cp0_status_ie   (cp0_status_ie),
        .cp0_status_exl  (cp0_status_exl),
        .cp0_status_im   (cp0_status_im),
        .cp0_cause_ip    (cp0_cause_ip),
        .ext_int_in      (ext_int_in),
        .int_ack         (int_ack),
        .fs_redirect_ack (fs_redirect_ack),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .int_req         (int_req),
        .ext_int_sync    (ext_int_sync),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a recovery is an outstanding job with a flush budget, then a
    // pending redirect; expected targets queue up and are popped when IF accepts.
    bit          m_busy, m_redir, m_int;
    int          m_fl;
    logic [5:0]  hist [SS];
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;
    bit          has_c, trig_c, nxt_int;

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_flush", 32'(flush), 32'd0);
            chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_int_req", 32'(int_req), 32'd0);
            chk("rst_redirect_pc", redirect_pc, VEC);
            chk("rst_ext_int_sync", 32'(ext_int_sync), 32'd0);
            m_busy = 0; m_redir = 0; m_int = 0; m_fl = 0;
            for (int i = 0; i < SS; i++) hist[i] = '0;
            exp_q.delete();
        end else begin
            chk("flush", 32'(flush), 32'(m_fl > 0));
            chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("int_req", 32'(int_req), 32'(m_int));
            chk("ext_int_sync", 32'(ext_int_sync), 32'(hist[SS-1]));
            if (redirect_valid && fs_redirect_ack) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL redirect_unexpected: got pc %h expected no redirect", redirect_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk("redirect_pc", redirect_pc, exp_pc);
                end
            end
            has_c   = ((cp0_cause_ip & cp0_status_im) != 8'h00) && cp0_status_ie && !cp0_status_exl;
            trig_c  = ws_valid && (ws_ex || ws_eret);
            nxt_int = !m_busy && has_c && !trig_c && !(int_ack && m_int);
            if (!m_busy) begin
                if (trig_c) begin
                    m_busy = 1;
                    m_fl   = FC;
                    exp_q.push_back(ws_ex ? VEC : cp0_epc);
                end
            end else if (m_fl > 0) begin
                m_fl--;
                if (m_fl == 0) m_redir = 1;
            end else if (m_redir && fs_redirect_ack) begin
                m_redir = 0;
                m_busy  = 0;
            end
            m_int = nxt_int;
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ext_int_in;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic commit(input logic ex, input logic eret, input logic [31:0] epc);
        ws_valid = 1; ws_ex = ex; ws_eret = eret; cp0_epc = epc;
        step();
        ws_valid = 0; ws_ex = 0; ws_eret = 0;
    endtask

    task automatic set_int(input logic ie, input logic exl, input logic [7:0] im, input logic [7:0] ip);
        cp0_status_ie = ie; cp0_status_exl = exl; cp0_status_im = im; cp0_cause_ip = ip;
    endtask

    initial begin
        resetn = 0; ws_valid = 0; ws_ex = 0; ws_eret = 0; cp0_epc = '0;
        set_int(0, 0, 8'h00, 8'h00);
        ext_int_in = '0; int_ack = 0; fs_redirect_ack = 0;
        step(3);
        resetn = 1;
        step(2);

        // exception: flush at T+1, redirect from T+2, ack at T+4
        commit(1, 0, 32'h1111_0000);
        chk("dir_flush_t1", 32'(flush), 32'd1);
        step();
        chk("dir_redir_t2", 32'(redirect_valid), 32'd1);
        chk("dir_redir_pc", redirect_pc, VEC);
        step();
        fs_redirect_ack = 1;
        step();
        fs_redirect_ack = 0;
        chk("dir_idle_t5", 32'(busy), 32'd0);
        step(2);

        // ERET with ack held, then exception+ERET together
        fs_redirect_ack = 1;
        commit(0, 1, 32'h8000_1234);
        step(3);
        commit(1, 1, 32'h8000_5678);
        step(3);
        fs_redirect_ack = 0;

        // interrupt request/ack, then masked by EXL
        set_int(1, 0, 8'h80, 8'h80);
        step(3);
        int_ack = 1;
        step();
        int_ack = 0;
        set_int(1, 1, 8'h80, 8'h80);
        step(4);

        // interrupt pending when a trigger arrives, re-raised only after return to IDLE
        set_int(1, 0, 8'h84, 8'h04);
        step(2);
        commit(1, 0, 32'h0);
        step(3);
        fs_redirect_ack = 1;
        step();
        fs_redirect_ack = 0;
        step(3);
        set_int(0, 0, 8'h00, 8'h00);

        // external line rises and propagates through the synchroniser
        ext_int_in[3] = 1;
        step(SS + 2);
        ext_int_in = '0;
        step(SS + 1);

        // reset during REDIR aborts immediately
        commit(0, 1, 32'h9000_0040);
        step(2);
        resetn = 0;
        #1;
        chk("async_flush", 32'(flush), 32'd0);
        chk("async_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_redirect_pc", redirect_pc, VEC);
        step(2);
        resetn = 1;
        step(2);

        // randomised traffic
        for (int c = 0; c < 4000; c++) begin
            ws_valid = ($urandom_range(0, 5) == 0);
            ws_ex    = 1'($urandom_range(0, 1));
            ws_eret  = 1'($urandom_range(0, 1));
            cp0_epc  = $urandom;
            if ($urandom_range(0, 11) == 0)
                set_int(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                        8'($urandom), 8'($urandom) & 8'($urandom));
            int_ack         = ($urandom_range(0, 2) == 0);
            fs_redirect_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) ext_int_in[$urandom_range(0, 5)] ^= 1'b1;
            if ($urandom_range(0, 599) == 0) begin
                resetn = 0;
                step(2);
                resetn = 1;
            end
            step();
        end

        // drain any outstanding recovery
        ws_valid = 0; int_ack = 0; fs_redirect_ack = 1;
        step(FC + 4);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
